// File: rtl/gpio_readback_pkg.sv
// rtl/gpio_readback_pkg.sv - shared constants, types and readback packing for the GPIO readback path
package gpio_readback_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 16;

  // Readback word layout: {sticky_change, filtered_level}
  localparam int LEVEL_LSB  = 0;
  localparam int CHANGE_LSB = 16;

  // Serial address of the bank-0 edge-enable register; banks 1..3 follow.
  localparam logic [6:0] DEF_ADDR_EDGE_EN_BASE = 7'd64;

  typedef logic [BANK_W-1:0] bank_word_t;

  // Assemble one readback word from a bank's sticky flags and filtered level.
  function automatic logic [31:0] pack_readback(input bank_word_t sticky, input bank_word_t level);
    logic [31:0] w;
    w = '0;
    w[CHANGE_LSB +: BANK_W] = sticky;
    w[LEVEL_LSB  +: BANK_W] = level;
    return w;
  endfunction

endpackage

// File: rtl/gpio_bank_filter.sv
// rtl/gpio_bank_filter.sv - one 16-bit bank: synchroniser, deglitch, edge-enable and sticky change flags
module gpio_bank_filter
  import gpio_readback_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  bank_word_t i_io,
  input  logic       i_tick,
  input  logic       i_wr_en,
  input  bank_word_t i_wr_mask,
  input  bank_word_t i_wr_value,
  input  logic       i_clr,
  output bank_word_t o_level,
  output bank_word_t o_sticky
);

  bank_word_t r_sync1;
  bank_word_t r_sync2;
  bank_word_t r_last;
  bank_word_t r_level;
  bank_word_t r_sticky;
  bank_word_t r_en;

  bank_word_t w_agree;
  bank_word_t w_level_next;
  bank_word_t w_change;
  bank_word_t w_sticky_next;
  bank_word_t w_en_next;

  // Next-state logic: a level bit only moves when two consecutive tick samples agree;
  // a change seen in the same cycle as a clear-on-read survives the clear.
  always_comb begin
    w_agree      = ~(r_sync2 ^ r_last);
    w_level_next = r_level;
    if (i_tick) begin
      w_level_next = (w_agree & r_sync2) | (~w_agree & r_level);
    end
    w_change      = w_level_next ^ r_level;
    w_sticky_next = (i_clr ? '0 : r_sticky) | (w_change & r_en);
    w_en_next     = r_en;
    if (i_wr_en) begin
      w_en_next = (r_en & ~i_wr_mask) | (i_wr_value & i_wr_mask);
    end
  end

  // Two-flop synchroniser for the asynchronous pin levels, clocked every cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_io;
      r_sync2 <= r_sync1;
    end
  end

  // Filter state: last tick sample, filtered level, sticky flags and edge enables.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last   <= '0;
      r_level  <= '0;
      r_sticky <= '0;
      r_en     <= '0;
    end else begin
      if (i_tick) begin
        r_last <= r_sync2;
      end
      r_level  <= w_level_next;
      r_sticky <= w_sticky_next;
      r_en     <= w_en_next;
    end
  end

  assign o_level  = r_level;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/gpio_readback.sv
// rtl/gpio_readback.sv - GPIO read side: sample prescaler, edge-enable write decode and readback handshake
module gpio_readback
  import gpio_readback_pkg::*;
#(
  parameter int         SAMPLE_DIV        = 4,
  parameter logic [6:0] ADDR_EDGE_EN_BASE = DEF_ADDR_EDGE_EN_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] io_0,
  input  logic [15:0] io_1,
  input  logic [15:0] io_2,
  input  logic [15:0] io_3,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        rd_req,
  input  logic [1:0]  rd_bank,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        change_pending
);

  localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0]     r_presc;
  logic                 w_tick;
  logic [NUM_BANKS-1:0] w_wr_hit;
  bank_word_t           w_io     [NUM_BANKS];
  bank_word_t           w_level  [NUM_BANKS];
  bank_word_t           w_sticky [NUM_BANKS];
  logic                 w_any_sticky;

  logic                 r_rd_ack;
  logic [31:0]          r_rd_data;
  logic                 r_pending;

  assign w_io[0] = io_0;
  assign w_io[1] = io_1;
  assign w_io[2] = io_2;
  assign w_io[3] = io_3;

  assign w_tick = (r_presc == CNT_LAST);

  // Sample prescaler: counts 0..SAMPLE_DIV-1 and fires the tick on the last count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_wr_hit[g] = serial_strobe && (serial_addr == ADDR_EDGE_EN_BASE + 7'(g));

    gpio_bank_filter u_filter (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_io       (w_io[g]),
      .i_tick     (w_tick),
      .i_wr_en    (w_wr_hit[g]),
      .i_wr_mask  (serial_data[31:16]),
      .i_wr_value (serial_data[15:0]),
      .i_clr      (rd_req && (rd_bank == 2'(g))),
      .o_level    (w_level[g]),
      .o_sticky   (w_sticky[g])
    );
  end

  // Any sticky flag across all banks.
  always_comb begin
    w_any_sticky = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_any_sticky = w_any_sticky | (|w_sticky[b]);
    end
  end

  // Readback: ack one cycle after the request, data captured from the request cycle and held.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
      r_pending <= 1'b0;
    end else begin
      r_rd_ack  <= rd_req;
      r_pending <= w_any_sticky;
      if (rd_req) begin
        r_rd_data <= pack_readback(w_sticky[rd_bank], w_level[rd_bank]);
      end
    end
  end

  assign rd_ack         = r_rd_ack;
  assign rd_data        = r_rd_data;
  assign change_pending = r_pending;

endmodule

// File: tb/tb_gpio_readback.sv
// tb/tb_gpio_readback.sv - self-checking bench for gpio_readback against a behavioural model
module tb_gpio_readback;

  localparam int SAMPLE_DIV = 4;
  localparam int SETTLE     = 2 + 2 * SAMPLE_DIV + 1 + 3;

  logic        clock;
  logic        reset;
  logic [15:0] io_0, io_1, io_2, io_3;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        rd_req;
  logic [1:0]  rd_bank;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        change_pending;

  int n_cmp;
  int n_bad;

  // Model state: pin values delayed through the synchroniser, last tick sample,
  // filtered level, sticky flags, enables, and the expected registered outputs.
  logic [15:0] m_delay  [4];
  logic [15:0] m_synced [4];
  logic [15:0] m_last   [4];
  logic [15:0] m_level  [4];
  logic [15:0] m_sticky [4];
  logic [15:0] m_en     [4];
  int          m_cnt;
  logic        m_ack;
  logic [31:0] m_data;
  logic        m_pend;

  gpio_readback #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_0           (io_0),
    .io_1           (io_1),
    .io_2           (io_2),
    .io_3           (io_3),
    .serial_addr    (serial_addr),
    .serial_data    (serial_data),
    .serial_strobe  (serial_strobe),
    .rd_req         (rd_req),
    .rd_bank        (rd_bank),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .change_pending (change_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    logic [15:0] pins [4];
    logic [15:0] new_level;
    logic        tick;
    pins[0] = io_0; pins[1] = io_1; pins[2] = io_2; pins[3] = io_3;
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_delay[b] = '0; m_synced[b] = '0; m_last[b] = '0;
        m_level[b] = '0; m_sticky[b] = '0; m_en[b] = '0;
      end
      m_cnt = 0; m_ack = 1'b0; m_data = '0; m_pend = 1'b0;
      return;
    end
    tick  = (m_cnt == SAMPLE_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_ack = rd_req;
    if (rd_req) m_data = {m_sticky[rd_bank], m_level[rd_bank]};
    m_pend = |(m_sticky[0] | m_sticky[1] | m_sticky[2] | m_sticky[3]);
    for (int b = 0; b < 4; b++) begin
      new_level = m_level[b];
      if (tick) begin
        for (int i = 0; i < 16; i++)
          if (m_synced[b][i] == m_last[b][i]) new_level[i] = m_synced[b][i];
        m_last[b] = m_synced[b];
      end
      if (rd_req && (int'(rd_bank) == b)) m_sticky[b] = '0;
      m_sticky[b] = m_sticky[b] | ((new_level ^ m_level[b]) & m_en[b]);
      m_level[b]  = new_level;
      if (serial_strobe && (int'(serial_addr) == 64 + b))
        m_en[b] = (m_en[b] & ~serial_data[31:16]) | (serial_data[15:0] & serial_data[31:16]);
      m_synced[b] = m_delay[b];
      m_delay[b]  = pins[b];
    end
  endtask

  // True when the model expects bank b bit i's filtered level to move at the next edge.
  function automatic logic change_due(input int b, input int i);
    return !reset && (m_cnt == SAMPLE_DIV - 1) && (m_synced[b][i] == m_last[b][i])
           && (m_synced[b][i] != m_level[b][i]);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_en(input logic [6:0] addr, input logic [31:0] data);
    serial_strobe = 1'b1; serial_addr = addr; serial_data = data;
    cycle();
    serial_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", rd_ack); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
    n_cmp++; if (change_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", change_pending); end
    reset = 1'b0;
    rd_req = 1'b1; rd_bank = 2'd2;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL first_read_ack: got %b want 1", rd_ack); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL first_read_data: got %h want 0", rd_data); end
    cycle();
    n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL first_read_ack_drop: got %b want 0", rd_ack); end
  endtask

  task automatic test_level_readback();
    io_0 = 16'h0005;
    write_en(7'd64, 32'h00FF_00FF);
    repeat (SETTLE) cycle();
    n_cmp++; if (change_pending !== 1'b1) begin n_bad++; $display("FAIL level_pending: got %b want 1", change_pending); end
    rd_req = 1'b1; rd_bank = 2'd0;
    cycle();
    n_cmp++; if (rd_data !== 32'h0005_0005 || rd_data !== m_data) begin n_bad++; $display("FAIL level_read1: got %h want 00050005 model %h", rd_data, m_data); end
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data !== 32'h0000_0005) begin n_bad++; $display("FAIL level_read2: got %h want 00000005", rd_data); end
    n_cmp++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL level_read2_ack: got %b want 1", rd_ack); end
    repeat (2) cycle();
    n_cmp++; if (change_pending !== 1'b0) begin n_bad++; $display("FAIL level_pending_clear: got %b want 0", change_pending); end
  endtask

  task automatic test_glitch();
    for (int b = 0; b < 4; b++) write_en(7'(64 + b), 32'hFFFF_FFFF);
    repeat (2) cycle();
    io_1[3] = 1'b1;
    repeat (3) cycle();
    io_1[3] = 1'b0;
    for (int k = 0; k < 2 * SETTLE; k++) begin
      cycle();
      n_cmp++; if (change_pending !== 1'b0) begin n_bad++; $display("FAIL glitch_pending cyc %0d: got %b want 0", k, change_pending); end
    end
    rd_req = 1'b1; rd_bank = 2'd1;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data !== 32'h0 || m_data !== 32'h0) begin n_bad++; $display("FAIL glitch_read: got %h want 0 model %h", rd_data, m_data); end
  endtask

  task automatic test_collision();
    logic found;
    found = 1'b0;
    io_3[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (change_due(3, 0)) begin
        rd_req = 1'b1; rd_bank = 2'd3;
        cycle();
        rd_req = 1'b0;
        found = 1'b1;
        n_cmp++; if (rd_ack !== 1'b1 || rd_data[16] !== 1'b0 || rd_data !== m_data) begin n_bad++; $display("FAIL collide_read1: got ack %b data %h want ack 1 change0 0 model %h", rd_ack, rd_data, m_data); end
        break;
      end
      cycle();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL collide_window: got no change edge want one within 40 cycles"); end
    cycle();
    rd_req = 1'b1; rd_bank = 2'd3;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data[16] !== 1'b1 || rd_data[0] !== 1'b1) begin n_bad++; $display("FAIL collide_read2: got %h want change0 1 level0 1", rd_data); end
    cycle();
  endtask

  task automatic test_disable();
    io_1[0] = 1'b1;
    repeat (SETTLE) cycle();
    n_cmp++; if (change_pending !== 1'b1) begin n_bad++; $display("FAIL disable_pending_set: got %b want 1", change_pending); end
    write_en(7'd65, 32'h0001_0000);
    cycle();
    n_cmp++; if (change_pending !== 1'b1) begin n_bad++; $display("FAIL disable_flag_kept: got %b want 1", change_pending); end
    rd_req = 1'b1; rd_bank = 2'd1;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data !== 32'h0001_0001) begin n_bad++; $display("FAIL disable_read1: got %h want 00010001", rd_data); end
    io_1[0] = 1'b0;
    repeat (SETTLE) cycle();
    rd_req = 1'b1; rd_bank = 2'd1;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data !== 32'h0000_0000) begin n_bad++; $display("FAIL disable_read2: got %h want 0", rd_data); end
    repeat (2) cycle();
    n_cmp++; if (change_pending !== 1'b0 || m_pend !== 1'b0) begin n_bad++; $display("FAIL disable_pending_clear: got %b want 0", change_pending); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(7) == 0) io_0 = io_0 ^ 16'($urandom & $urandom);
      if ($urandom_range(7) == 0) io_1 = io_1 ^ 16'($urandom & $urandom);
      if ($urandom_range(7) == 0) io_2 = io_2 ^ 16'($urandom & $urandom);
      if ($urandom_range(7) == 0) io_3 = io_3 ^ 16'($urandom & $urandom);
      rd_req  = ($urandom_range(3) == 0);
      rd_bank = 2'($urandom);
      serial_strobe = ($urandom_range(9) == 0);
      serial_addr   = 7'(62 + $urandom_range(7));
      serial_data   = $urandom;
      cycle();
      n_cmp++; if (rd_ack !== m_ack) begin n_bad++; $display("FAIL rand_ack cyc %0d: got %b want %b", k, rd_ack, m_ack); end
      n_cmp++; if (rd_data !== m_data) begin n_bad++; $display("FAIL rand_data cyc %0d: got %h want %h", k, rd_data, m_data); end
      n_cmp++; if (change_pending !== m_pend) begin n_bad++; $display("FAIL rand_pending cyc %0d: got %b want %b", k, change_pending, m_pend); end
    end
    rd_req = 1'b0; serial_strobe = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    io_0 = 16'($urandom); io_1 = 16'($urandom); io_2 = 16'($urandom); io_3 = 16'($urandom);
    repeat (SETTLE) cycle();
    for (int b = 0; b < 3; b++) begin
      rd_req = 1'b1; rd_bank = 2'(b);
      cycle();
      n_cmp++; if (rd_ack !== 1'b1 || rd_data !== m_data) begin n_bad++; $display("FAIL b2b_bank%0d: got ack %b data %h want ack 1 data %h", b, rd_ack, rd_data, m_data); end
    end
    rd_req = 1'b0;
    cycle();
    n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_drop: got %b want 0", rd_ack); end
    n_cmp++; if (rd_data[15:0] !== io_2) begin n_bad++; $display("FAIL b2b_hold: got %h want level %h", rd_data[15:0], io_2); end
    rd_req = 1'b1; rd_bank = 2'd0;
    cycle();
    n_cmp++; if (rd_ack !== 1'b1 || rd_data !== m_data) begin n_bad++; $display("FAIL b2b_reset_first: got ack %b data %h want ack 1 data %h", rd_ack, rd_data, m_data); end
    rd_bank = 2'd1; reset = 1'b1;
    cycle();
    n_cmp++; if (rd_ack !== 1'b0 || rd_data !== 32'h0 || change_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_reset_mid: got ack %b data %h pend %b want all 0", rd_ack, rd_data, change_pending); end
    rd_bank = 2'd2;
    cycle();
    reset = 1'b0; rd_req = 1'b0;
    cycle();
    n_cmp++; if (rd_ack !== 1'b0 || rd_data !== 32'h0 || change_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_after_reset: got ack %b data %h pend %b want all 0", rd_ack, rd_data, change_pending); end
    repeat (SETTLE) cycle();
    rd_req = 1'b1; rd_bank = 2'd0;
    cycle();
    rd_req = 1'b0;
    n_cmp++; if (rd_data !== {16'h0, io_0} || rd_data !== m_data) begin n_bad++; $display("FAIL b2b_post_reset_read: got %h want %h", rd_data, {16'h0, io_0}); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    io_0 = '0; io_1 = '0; io_2 = '0; io_3 = '0;
    serial_addr = '0; serial_data = '0; serial_strobe = 1'b0;
    rd_req = 1'b0; rd_bank = '0;
    m_cnt = 0; m_ack = 1'b0; m_data = '0; m_pend = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_delay[b] = '0; m_synced[b] = '0; m_last[b] = '0;
      m_level[b] = '0; m_sticky[b] = '0; m_en[b] = '0;
    end
    @(posedge clock);
    #1;
    test_reset();
    test_level_readback();
    test_glitch();
    test_collision();
    test_disable();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_readback.md
Name: gpio_readback

Overview:
Read-side counterpart to the GPIO output/OE path. It samples the four 16-bit I/O banks, synchronises and deglitches them, and latches per-bit sticky change flags. It serves single-cycle readback requests from the serial/readback mux, and sits beside the OE/tristate logic on the same serial write bus.

Parameters:
SAMPLE_DIV, 4, clocks per sample tick (>=1); 1 means sample every clock.
ADDR_EDGE_EN_BASE, 7'd64, serial_addr of bank-0 edge-enable register; banks 1..3 at +1..+3.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
io_0  in  16  bank 0 pin levels (asynchronous)
io_1  in  16  bank 1 pin levels (asynchronous)
io_2  in  16  bank 2 pin levels (asynchronous)
io_3  in  16  bank 3 pin levels (asynchronous)
serial_addr  in  7  serial write address
serial_data  in  32  serial write data; [31:16] mask, [15:0] value
serial_strobe  in  1  serial write strobe
rd_req  in  1  readback request pulse
rd_bank  in  2  bank selected by rd_req
rd_ack  out  1  readback data valid
rd_data  out  32  {sticky_change[15:0], filtered_level[15:0]}
change_pending  out  1  OR of all sticky change bits

Behaviour:
- Reset values: rd_ack=0, rd_data=0, change_pending=0. All sync flops, filtered levels, sticky flags and edge-enable registers are cleared. The prescaler restarts at 0.
- Synchroniser: 2-flop per bit, every clock, unconditionally. Reset clears the flops to 0.
- Prescaler: counter 0..SAMPLE_DIV-1. A tick fires when the counter = SAMPLE_DIV-1, then the counter wraps to 0. With SAMPLE_DIV=1 the tick fires every clock.
- Deglitch: on each tick, store the synced value as the last sample. filtered_level bit updates to the synced value only if the current synced bit equals the last sample bit, i.e. two consecutive ticks agree. Worst-case pin-to-level latency is 2 sync cycles + 2*SAMPLE_DIV + 1.
- Change detect: a bit sets its sticky flag in the cycle its filtered_level changes, if its edge-enable bit is 1. Both edge directions count. A change on a disabled bit never sets the flag.
- Edge-enable write: on serial_strobe with serial_addr = base+n:
  - en_n <= (en_n & ~data[31:16]) | (data[15:0] & data[31:16]).
  - Other addresses are ignored.
  - Clearing an enable bit does not clear an already-set sticky flag.
- Readback: rd_req in cycle N gives rd_ack=1 in cycle N+1 for exactly one cycle. rd_data captures {sticky_n, level_n} as of cycle N.
- rd_data holds its value until the next request; it is not cleared when rd_ack drops.
- Clear-on-read: the selected bank's sticky flags clear at the end of cycle N.
  - A new change on the same bit in cycle N wins: the flag stays set and is reported on the next read.
  - Other banks are untouched.
- Back-to-back: rd_req on consecutive cycles is legal; each request gets its own rd_ack.
- change_pending is registered: it reflects the sticky state one cycle later.
- Reset mid-read: rd_ack for an in-flight request is suppressed, and all flags are lost.

Decomposition:
- Shared package/include: readback field offsets (LEVEL_LSB=0, CHANGE_LSB=16) and the ADDR_EDGE_EN_BASE value, added beside the existing FR_* register defines.
- One natural sub-module, gpio_bank_filter, instantiated 4 times. It contains the 16-bit synchroniser, deglitch, edge-enable register and sticky flags.
- The top level holds the prescaler, the write decode and the readback mux/handshake.

Test Plan:
- Reset, then rd_req bank 2 -> rd_ack one cycle later; rd_data=32'h0000_0000; change_pending=0.
- Write addr 64 data 32'h00FF_00FF; drive io_0=16'h0005 stably. After filter latency, read bank 0 -> rd_data=32'h0005_0005. Read again -> 32'h0000_0005.
- With SAMPLE_DIV=4, pulse io_1[3] high for 3 clocks with all banks enabled -> filtered level unchanged; no sticky flag; change_pending stays 0.
- Enable bank 3 bit 0, toggle io_3[0] so its filtered change lands in the same cycle as rd_req bank 3. The first read is taken before the flag sets, so it returns change=0 -> the next read returns change bit 0 = 1.
- Write addr 65 data 32'h0001_0000 (mask bit0, value 0) after flag set -> enable cleared; flag remains until read; subsequent io_1[0] edges set nothing.
- rd_req on 3 consecutive cycles for banks 0,1,2 -> three consecutive rd_ack pulses, each rd_data matching its bank; reset asserted during the second request -> no further rd_ack; all outputs 0.
